ring_decoder: RTL and testbench

Receive-side companion to the ring counter. It samples a one-hot ring word on each enabled step and converts it to a binary index. It checks that every word is one-hot and is exactly a one-position left rotation of the previous word. It also tracks lock and counts laps and errors. It sits downstream of any `ring_counter` instance and can be fed directly from that counter's `count` output, or from a copy of it carried across the design.

---
 rtl/ring_decoder.sv | 173 +++++++++++++++++
 tb/tb_ring_decoder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ring_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ring_decoder
// Brief    : Receive-side checker for a one-hot ring counter. Samples the ring
//            word on enabled edges. It converts the word to a binary index,
//            checks that the word is one-hot and is a one-position left
//            rotation of the previous word, and tracks lock, laps and errors.
// Options  : RING_DECODER_ERRCNT_EN - build the saturating 8-bit err_count
//            register. When the macro is undefined, err_count is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module ring_decoder #(
   parameter int word_size  = 8,
   parameter int lock_count = 4,
   parameter int lap_w      = 8
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         enable,
   input  logic [word_size-1:0]         ring,
   output logic [$clog2(word_size)-1:0] index,
   output logic                         valid,
   output logic                         onehot_err,
   output logic                         seq_err,
   output logic                         locked,
   output logic [lap_w-1:0]             lap_count,
   output logic [7:0]                   err_count
);

   localparam int                   c_idx_w   = $clog2(word_size);
   localparam logic [word_size-1:0] c_one     = word_size'(1);
   localparam logic [lap_w-1:0]     c_lap_one = lap_w'(1);
   localparam logic [7:0]           c_lock    = 8'(lock_count);

   typedef enum logic [1:0] {
      SEEK = 2'd0,
      SYNC = 2'd1,
      LOCK = 2'd2
   } state_t;

   state_t               r_state,      w_state_nxt;
   logic [word_size-1:0] r_expected,   w_expected_nxt;
   logic [7:0]           r_good_cnt,   w_good_nxt;
   logic [c_idx_w-1:0]   r_index,      w_index_nxt;
   logic                 r_valid,      w_valid_nxt;
   logic                 r_onehot_err, w_onehot_err_nxt;
   logic                 r_seq_err,    w_seq_err_nxt;
   logic                 r_locked,     w_locked_nxt;
   logic [lap_w-1:0]     r_lap_count,  w_lap_nxt;

   logic                 w_onehot;
   logic [word_size-1:0] w_rot;
   logic [c_idx_w-1:0]   w_pos;
   logic [7:0]           w_good_inc;

   // Clearing the lowest set bit leaves zero only when exactly one bit is set.
   assign w_onehot   = (ring != '0) && ((ring & (ring - c_one)) == '0);
   assign w_rot      = {ring[word_size-2:0], ring[word_size-1]};
   assign w_good_inc = r_good_cnt + 8'd1;

   // Binary position of the set bit. The result is used only when the word is one-hot.
   always_comb begin
      w_pos = '0;
      for (int i = 0; i < word_size; i++) begin
         if (ring[i]) begin
            w_pos = c_idx_w'(i);
         end
      end
   end

   // Next-state and next-output logic. A disabled edge holds everything and clears the pulses.
   always_comb begin
      w_state_nxt      = r_state;
      w_expected_nxt   = r_expected;
      w_good_nxt       = r_good_cnt;
      w_index_nxt      = r_index;
      w_valid_nxt      = r_valid;
      w_onehot_err_nxt = 1'b0;
      w_seq_err_nxt    = 1'b0;
      w_lap_nxt        = r_lap_count;
      if (enable) begin
         if (!w_onehot) begin
            // A malformed word invalidates any tracking. Start the search again.
            w_onehot_err_nxt = 1'b1;
            w_valid_nxt      = 1'b0;
            w_state_nxt      = SEEK;
            w_good_nxt       = 8'd0;
         end else begin
            w_index_nxt = w_pos;
            w_valid_nxt = 1'b1;
            case (r_state)
               SYNC, LOCK: begin
                  if (ring == r_expected) begin
                     w_expected_nxt = w_rot;
                     if (r_state == SYNC) begin
                        w_good_nxt = w_good_inc;
                        if (w_good_inc == c_lock) begin
                           w_state_nxt = LOCK;
                        end
                     end else if (ring[0]) begin
                        w_lap_nxt = r_lap_count + c_lap_one;
                     end
                  end else begin
                     // The word is one-hot but out of sequence. Re-seed from it.
                     w_seq_err_nxt  = 1'b1;
                     w_expected_nxt = w_rot;
                     w_good_nxt     = 8'd0;
                     w_state_nxt    = SYNC;
                  end
               end
               default: begin
                  // SEEK: the first good word only seeds the prediction.
                  w_expected_nxt = w_rot;
                  w_good_nxt     = 8'd0;
                  w_state_nxt    = SYNC;
               end
            endcase
         end
      end
      w_locked_nxt = (w_state_nxt == LOCK);
   end

   // State and output registers. Reset takes priority over any sample.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= SEEK;
         r_expected   <= '0;
         r_good_cnt   <= 8'd0;
         r_index      <= '0;
         r_valid      <= 1'b0;
         r_onehot_err <= 1'b0;
         r_seq_err    <= 1'b0;
         r_locked     <= 1'b0;
         r_lap_count  <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_expected   <= w_expected_nxt;
         r_good_cnt   <= w_good_nxt;
         r_index      <= w_index_nxt;
         r_valid      <= w_valid_nxt;
         r_onehot_err <= w_onehot_err_nxt;
         r_seq_err    <= w_seq_err_nxt;
         r_locked     <= w_locked_nxt;
         r_lap_count  <= w_lap_nxt;
      end
   end

`ifdef RING_DECODER_ERRCNT_EN
   logic [7:0] r_err_count;

   // Error counter. It counts either pulse and stops at 255.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_err_count <= 8'd0;
      end else if ((w_onehot_err_nxt || w_seq_err_nxt) && (r_err_count != 8'hFF)) begin
         r_err_count <= r_err_count + 8'd1;
      end
   end

   assign err_count = r_err_count;
`else
   assign err_count = 8'd0;
`endif

   assign index      = r_index;
   assign valid      = r_valid;
   assign onehot_err = r_onehot_err;
   assign seq_err    = r_seq_err;
   assign locked     = r_locked;
   assign lap_count  = r_lap_count;

endmodule
`default_nettype wire

// File: tb/tb_ring_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ring_decoder
// Brief    : Self-checking bench for ring_decoder (8-bit ring, lock after 4
//            matches, 8-bit lap counter). A behavioural reference model
//            pushes the expected outputs for each driven sample into a queue.
//            The queue is popped and compared after the clock edge.
// Options  : RING_DECODER_ERRCNT_EN - selects the expected err_count behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ring_decoder;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [7:0] ring = 8'h00;
   logic [2:0] index;
   logic       valid, onehot_err, seq_err, locked;
   logic [7:0] lap_count, err_count;

   ring_decoder #(.word_size(8), .lock_count(4), .lap_w(8)) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .ring       (ring),
      .index      (index),
      .valid      (valid),
      .onehot_err (onehot_err),
      .seq_err    (seq_err),
      .locked     (locked),
      .lap_count  (lap_count),
      .err_count  (err_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [2:0] index;
      logic       valid;
      logic       oh;
      logic       seq;
      logic       locked;
      logic [7:0] lap;
      logic [7:0] err;
   } exp_t;

   exp_t q_exp[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model state: 0 = SEEK, 1 = SYNC, 2 = LOCK.
   int         m_state;
   logic [7:0] m_exp;
   int         m_good;
   exp_t       m_out;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
      end
   endtask

   task automatic model(input logic rst, input logic en, input logic [7:0] r);
      if (rst) begin
         m_state = 0; m_exp = 8'h00; m_good = 0;
         m_out = '{index: 3'd0, valid: 1'b0, oh: 1'b0, seq: 1'b0, locked: 1'b0, lap: 8'd0, err: 8'd0};
      end else begin
         m_out.oh  = 1'b0;
         m_out.seq = 1'b0;
         if (en) begin
            if ($countones(r) != 1) begin
               m_out.oh = 1'b1; m_out.valid = 1'b0; m_state = 0; m_good = 0;
            end else begin
               for (int i = 0; i < 8; i++) if (r[i]) m_out.index = 3'(i);
               m_out.valid = 1'b1;
               if (m_state == 0) begin
                  m_exp = {r[6:0], r[7]}; m_good = 0; m_state = 1;
               end else if (r == m_exp) begin
                  m_exp = {r[6:0], r[7]};
                  if (m_state == 1) begin
                     m_good++;
                     if (m_good == 4) m_state = 2;
                  end else if (r[0]) begin
                     m_out.lap = m_out.lap + 8'd1;
                  end
               end else begin
                  m_out.seq = 1'b1; m_exp = {r[6:0], r[7]}; m_good = 0; m_state = 1;
               end
            end
            m_out.locked = (m_state == 2);
`ifdef RING_DECODER_ERRCNT_EN
            if ((m_out.oh || m_out.seq) && m_out.err != 8'hFF) m_out.err = m_out.err + 8'd1;
`endif
         end
      end
   endtask

   // Drive one sample, record the expectation, then check after the edge.
   task automatic step(input logic rst, input logic en, input logic [7:0] r);
      exp_t e;
      reset = rst; enable = en; ring = r;
      model(rst, en, r);
      q_exp.push_back(m_out);
      @(posedge clock);
      #1;
      if (q_exp.size() == 0) begin
         check("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         e = q_exp.pop_front();
         check("index",      32'(index),      32'(e.index));
         check("valid",      32'(valid),      32'(e.valid));
         check("onehot_err", 32'(onehot_err), 32'(e.oh));
         check("seq_err",    32'(seq_err),    32'(e.seq));
         check("locked",     32'(locked),     32'(e.locked));
         check("lap_count",  32'(lap_count),  32'(e.lap));
         check("err_count",  32'(err_count),  32'(e.err));
      end
   endtask

   task automatic feed(input logic [7:0] r);
      step(1'b0, 1'b1, r);
   endtask

   initial begin
      logic [7:0] v;
      m_state = 0; m_exp = 8'h00; m_good = 0;
      m_out = '{index: 3'd0, valid: 1'b0, oh: 1'b0, seq: 1'b0, locked: 1'b0, lap: 8'd0, err: 8'd0};
      @(negedge clock);
      // Reset state
      step(1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b0, 8'h00);
      // Lock-in
      feed(8'h01); feed(8'h02); feed(8'h04); feed(8'h08); feed(8'h10);
      check("lockin_locked", 32'(locked), 32'd1);
      // Lap, including the 0x80 -> 0x01 wrap
      feed(8'h20); feed(8'h40); feed(8'h80); feed(8'h01);
      check("lap_one", 32'(lap_count), 32'd1);
      // Back-to-back one-hot errors (multi-bit, then zero)
      feed(8'h03); feed(8'h00);
      check("oh_pulse_back_to_back", 32'(onehot_err), 32'd1);
      // Re-lock, move to where 0x04 is expected, then break the sequence
      feed(8'h01); feed(8'h02); feed(8'h04); feed(8'h08); feed(8'h10);
      feed(8'h20); feed(8'h40); feed(8'h80); feed(8'h01); feed(8'h02);
      feed(8'h10);
      check("seq_err_index", 32'(index), 32'd4);
      feed(8'h20); feed(8'h40); feed(8'h80); feed(8'h01);
      check("relock", 32'(locked), 32'd1);
      // Strobe hold with a garbage word on the input
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'hFF);
      feed(8'h02);
      // Reset together with enable while locked
      step(1'b1, 1'b1, 8'h04);
      feed(8'h08);   // seed only after reset
      feed(8'h10);
      // Mixed sample pattern: mostly the expected word, sometimes arbitrary
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0 || m_exp == 8'h00) v = 8'($urandom_range(0, 255));
         else v = m_exp;
         if ($urandom_range(0, 9) == 0) step(1'b0, 1'b0, v);
         else feed(v);
      end
      // Error counter saturation (or stays zero without the counter build)
      for (int i = 0; i < 300; i++) feed(8'h00);
`ifdef RING_DECODER_ERRCNT_EN
      check("err_saturated", 32'(err_count), 32'd255);
`else
      check("err_tied_zero", 32'(err_count), 32'd0);
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
